// File: rtl/friscv_gpio_bank_if.sv
// Slave-side bus bundle for the GPIO bank: en/wr/addr/wdata/strb request
// with a one-cycle ready pulse carrying read data.
interface friscv_gpio_bank_if #(
    parameter int ADDRW = 15,
    parameter int XLEN  = 32
);

    logic              slv_en;
    logic              slv_wr;
    logic [ADDRW-1:0]  slv_addr;
    logic [XLEN-1:0]   slv_wdata;
    logic [XLEN/8-1:0] slv_strb;
    logic [XLEN-1:0]   slv_rdata;
    logic              slv_ready;

    modport master (
        output slv_en,
        output slv_wr,
        output slv_addr,
        output slv_wdata,
        output slv_strb,
        input  slv_rdata,
        input  slv_ready
    );

    modport slave (
        input  slv_en,
        input  slv_wr,
        input  slv_addr,
        input  slv_wdata,
        input  slv_strb,
        output slv_rdata,
        output slv_ready
    );

endinterface

// File: rtl/friscv_gpio_bank.sv
// Parametrised GPIO bank: direction control, atomic set/clear of outputs,
// synchronised inputs and per-pin rise/fall interrupts with W1C pending bits.
module friscv_gpio_bank #(
    parameter int ADDRW       = 15,
    parameter int XLEN        = 32,
    parameter int NB_GPIO     = 32,
    parameter int SYNC_STAGES = 2
)(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               srst,
    friscv_gpio_bank_if.slave  slv,
    input  logic [NB_GPIO-1:0] gpio_in,
    output logic [NB_GPIO-1:0] gpio_out,
    output logic [NB_GPIO-1:0] gpio_oe,
    output logic               irq
);

    localparam int NBYTES = XLEN / 8;

    localparam logic [ADDRW-1:0] ADDR_OUT     = ADDRW'(0);
    localparam logic [ADDRW-1:0] ADDR_IN      = ADDRW'(1);
    localparam logic [ADDRW-1:0] ADDR_DIR     = ADDRW'(2);
    localparam logic [ADDRW-1:0] ADDR_IE_RISE = ADDRW'(3);
    localparam logic [ADDRW-1:0] ADDR_IE_FALL = ADDRW'(4);
    localparam logic [ADDRW-1:0] ADDR_PEND    = ADDRW'(5);
    localparam logic [ADDRW-1:0] ADDR_SET     = ADDRW'(6);
    localparam logic [ADDRW-1:0] ADDR_CLR     = ADDRW'(7);

    logic [NB_GPIO-1:0] out_q,     out_d;
    logic [NB_GPIO-1:0] dir_q,     dir_d;
    logic [NB_GPIO-1:0] ie_rise_q, ie_rise_d;
    logic [NB_GPIO-1:0] ie_fall_q, ie_fall_d;
    logic [NB_GPIO-1:0] pend_q,    pend_d;
    logic [NB_GPIO-1:0] prev_q,    prev_d;
    logic [NB_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [NB_GPIO-1:0] sync_d [SYNC_STAGES];
    logic               irq_q,     irq_d;
    logic               ready_q,   ready_d;
    logic [XLEN-1:0]    rdata_q,   rdata_d;

    logic               acc;
    logic               wr_acc;
    logic [XLEN-1:0]    byte_mask;
    logic [NB_GPIO-1:0] wbits;
    logic [NB_GPIO-1:0] w1c_mask;
    logic [NB_GPIO-1:0] rd_bits;
    logic [NB_GPIO-1:0] sync;
    logic [NB_GPIO-1:0] rise;
    logic [NB_GPIO-1:0] fall;

    // A request held through its own ready cycle must not be taken twice.
    assign acc    = slv.slv_en & ~ready_q;
    assign wr_acc = acc & slv.slv_wr;

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            byte_mask[b*8 +: 8] = {8{slv.slv_strb[b]}};
        end
    end

    assign wbits = slv.slv_wdata[NB_GPIO-1:0] & byte_mask[NB_GPIO-1:0];

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

    always_comb begin
        rd_bits = '0;
        case (slv.slv_addr)
            ADDR_OUT:     rd_bits = out_q;
            ADDR_IN:      rd_bits = sync;
            ADDR_DIR:     rd_bits = dir_q;
            ADDR_IE_RISE: rd_bits = ie_rise_q;
            ADDR_IE_FALL: rd_bits = ie_fall_q;
            ADDR_PEND:    rd_bits = pend_q;
            default:      rd_bits = '0;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        ie_rise_d = ie_rise_q;
        ie_fall_d = ie_fall_q;
        w1c_mask  = '0;

        if (wr_acc) begin
            case (slv.slv_addr)
                ADDR_OUT:     out_d     = (out_q & ~byte_mask[NB_GPIO-1:0]) | wbits;
                ADDR_DIR:     dir_d     = (dir_q & ~byte_mask[NB_GPIO-1:0]) | wbits;
                ADDR_IE_RISE: ie_rise_d = (ie_rise_q & ~byte_mask[NB_GPIO-1:0]) | wbits;
                ADDR_IE_FALL: ie_fall_d = (ie_fall_q & ~byte_mask[NB_GPIO-1:0]) | wbits;
                ADDR_PEND:    w1c_mask  = wbits;
                ADDR_SET:     out_d     = out_q | wbits;
                ADDR_CLR:     out_d     = out_q & ~wbits;
                default:      out_d     = out_q;
            endcase
        end

        // OR-ing new edges after the clear lets an edge win over a same-cycle W1C.
        pend_d = (pend_q & ~w1c_mask) | (rise & ie_rise_q) | (fall & ie_fall_q);
        irq_d  = |pend_q;

        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync;

        ready_d = acc;
        rdata_d = '0;
        if (acc && !slv.slv_wr) begin
            rdata_d[NB_GPIO-1:0] = rd_bits;
        end

        // Synchronous reset shares the asynchronous reset values.
        if (srst) begin
            out_d     = '0;
            dir_d     = '0;
            ie_rise_d = '0;
            ie_fall_d = '0;
            pend_d    = '0;
            prev_d    = '0;
            irq_d     = 1'b0;
            ready_d   = 1'b0;
            rdata_d   = '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_d[i] = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q     <= '0;
            dir_q     <= '0;
            ie_rise_q <= '0;
            ie_fall_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            ie_rise_q <= ie_rise_d;
            ie_fall_q <= ie_fall_d;
            pend_q    <= pend_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign slv.slv_ready = ready_q;
    assign slv.slv_rdata = rdata_q;
    assign gpio_out      = out_q;
    assign gpio_oe       = dir_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_friscv_gpio_bank.sv
// Directed bench for friscv_gpio_bank: register table plus hand-written
// sequences for edge interrupts, W1C races, held requests and resets.
module tb_friscv_gpio_bank;

    localparam int ADDRW = 15;
    localparam int XLEN  = 32;
    localparam int SYNC  = 2;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        srst    = 1'b0;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [7:0]  gpio_out8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] rd, rd8, outSnap, oeSnap;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chkRd;
        logic [31:0] expRd;
        logic [31:0] expOut;
        logic [31:0] expOe;
    } vec_t;

    vec_t vecs [21];

    always #5 aclk = ~aclk;

    friscv_gpio_bank_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus  ();
    friscv_gpio_bank_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus8 ();

    // The 8-pin instance sees every access issued on the main bus.
    assign bus8.slv_en    = bus.slv_en;
    assign bus8.slv_wr    = bus.slv_wr;
    assign bus8.slv_addr  = bus.slv_addr;
    assign bus8.slv_wdata = bus.slv_wdata;
    assign bus8.slv_strb  = bus.slv_strb;

    friscv_gpio_bank #(.ADDRW(ADDRW), .XLEN(XLEN), .NB_GPIO(32), .SYNC_STAGES(SYNC)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .slv      (bus.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    friscv_gpio_bank #(.ADDRW(ADDRW), .XLEN(XLEN), .NB_GPIO(8), .SYNC_STAGES(SYNC)) dut8 (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .slv      (bus8.slave),
        .gpio_in  (gpio_in[7:0]),
        .gpio_out (gpio_out8),
        .gpio_oe  (gpio_oe8),
        .irq      (irq8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [14:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 output logic [31:0] rdo, output logic [31:0] rdo8,
                                 output logic [31:0] outo, output logic [31:0] oeo);
        @(negedge aclk);
        bus.slv_en    = 1'b1;
        bus.slv_wr    = wr;
        bus.slv_addr  = addr;
        bus.slv_wdata = wdata;
        bus.slv_strb  = strb;
        @(posedge aclk);
        #1;
        checkOutput("ready_high", 32'(bus.slv_ready), 32'd1);
        rdo  = bus.slv_rdata;
        rdo8 = bus8.slv_rdata;
        outo = gpio_out;
        oeo  = gpio_oe;
        bus.slv_en = 1'b0;
        bus.slv_wr = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("ready_low", 32'(bus.slv_ready), 32'd0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        bus.slv_en    = 1'b0;
        bus.slv_wr    = 1'b0;
        bus.slv_addr  = '0;
        bus.slv_wdata = '0;
        bus.slv_strb  = '0;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b0, 15'(i), 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 32'h0};
        end
        vecs[8]  = '{1'b1, 15'd0,     32'h98765432, 4'hF, 1'b0, 32'h0,        32'h98765432, 32'h0};
        vecs[9]  = '{1'b1, 15'd0,     32'hFFFFFFFF, 4'h2, 1'b0, 32'h0,        32'h9876FF32, 32'h0};
        vecs[10] = '{1'b1, 15'd6,     32'h00000001, 4'hF, 1'b0, 32'h0,        32'h9876FF33, 32'h0};
        vecs[11] = '{1'b1, 15'd7,     32'h80000000, 4'hF, 1'b0, 32'h0,        32'h1876FF33, 32'h0};
        vecs[12] = '{1'b0, 15'd0,     32'h0,        4'h0, 1'b1, 32'h1876FF33, 32'h1876FF33, 32'h0};
        vecs[13] = '{1'b0, 15'd6,     32'h0,        4'h0, 1'b1, 32'h0,        32'h1876FF33, 32'h0};
        vecs[14] = '{1'b0, 15'd7,     32'h0,        4'h0, 1'b1, 32'h0,        32'h1876FF33, 32'h0};
        vecs[15] = '{1'b1, 15'd2,     32'hFFFFFFFF, 4'h3, 1'b0, 32'h0,        32'h1876FF33, 32'h0000FFFF};
        vecs[16] = '{1'b0, 15'd2,     32'h0,        4'h0, 1'b1, 32'h0000FFFF, 32'h1876FF33, 32'h0000FFFF};
        vecs[17] = '{1'b1, 15'h1000,  32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        32'h1876FF33, 32'h0000FFFF};
        vecs[18] = '{1'b0, 15'h1000,  32'h0,        4'h0, 1'b1, 32'h0,        32'h1876FF33, 32'h0000FFFF};
        vecs[19] = '{1'b1, 15'd7,     32'h00FF0000, 4'hC, 1'b0, 32'h0,        32'h1800FF33, 32'h0000FFFF};
        vecs[20] = '{1'b1, 15'd6,     32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        32'h1800FF33, 32'h0000FFFF};

        waitCycles(3);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checkOutput("reset_gpio_out", gpio_out, 32'h0);
        checkOutput("reset_gpio_oe", gpio_oe, 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_ready", 32'(bus.slv_ready), 32'h0);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, rd8, outSnap, oeSnap);
            if (vecs[i].chkRd) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
            checkOutput($sformatf("vec%0d_gpio_out", i), outSnap, vecs[i].expOut);
            checkOutput($sformatf("vec%0d_gpio_oe", i), oeSnap, vecs[i].expOe);
        end

        // Request held through its ready cycle is taken again only one cycle later.
        @(negedge aclk);
        bus.slv_en   = 1'b1;
        bus.slv_wr   = 1'b0;
        bus.slv_addr = 15'd0;
        waitCycles(1);
        checkOutput("held_ready_1", 32'(bus.slv_ready), 32'd1);
        waitCycles(1);
        checkOutput("held_ready_gap", 32'(bus.slv_ready), 32'd0);
        waitCycles(1);
        checkOutput("held_ready_2", 32'(bus.slv_ready), 32'd1);
        checkOutput("held_rdata_2", bus.slv_rdata, 32'h1800FF33);
        bus.slv_en = 1'b0;
        waitCycles(1);
        checkOutput("held_ready_end", 32'(bus.slv_ready), 32'd0);

        // Input synchronisation and pin-count truncation.
        @(negedge aclk);
        gpio_in = 32'hA5A5A5A5;
        waitCycles(SYNC);
        applyStimulus(1'b0, 15'd1, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("in_read_32", rd, 32'hA5A5A5A5);
        checkOutput("in_read_8", rd8, 32'h000000A5);
        @(negedge aclk);
        gpio_in = 32'h0;
        waitCycles(5);

        // Rising edge interrupt: PEND after SYNC+1 edges, irq one edge later.
        applyStimulus(1'b1, 15'd3, 32'h1, 4'hF, rd, rd8, outSnap, oeSnap);
        @(negedge aclk);
        gpio_in[0] = 1'b1;
        waitCycles(SYNC + 1);
        checkOutput("rise_irq_not_yet", 32'(irq), 32'd0);
        waitCycles(1);
        checkOutput("rise_irq_set", 32'(irq), 32'd1);
        applyStimulus(1'b0, 15'd5, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("rise_pend", rd, 32'h1);
        applyStimulus(1'b1, 15'd5, 32'h1, 4'hF, rd, rd8, outSnap, oeSnap);
        applyStimulus(1'b0, 15'd5, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("w1c_pend", rd, 32'h0);
        checkOutput("w1c_irq", 32'(irq), 32'd0);

        // Same toggle with the rise enable cleared raises nothing.
        @(negedge aclk);
        gpio_in[0] = 1'b0;
        waitCycles(5);
        applyStimulus(1'b1, 15'd3, 32'h0, 4'hF, rd, rd8, outSnap, oeSnap);
        @(negedge aclk);
        gpio_in[0] = 1'b1;
        waitCycles(6);
        checkOutput("no_ie_irq", 32'(irq), 32'd0);
        applyStimulus(1'b0, 15'd5, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("no_ie_pend", rd, 32'h0);

        // Fall edge on pin 3 lands on the same edge as a W1C of that bit.
        @(negedge aclk);
        gpio_in[3] = 1'b1;
        waitCycles(5);
        applyStimulus(1'b1, 15'd4, 32'h8, 4'hF, rd, rd8, outSnap, oeSnap);
        @(negedge aclk);
        gpio_in[3] = 1'b0;
        repeat (SYNC - 1) @(negedge aclk);
        applyStimulus(1'b1, 15'd5, 32'h8, 4'hF, rd, rd8, outSnap, oeSnap);
        applyStimulus(1'b0, 15'd5, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("race_pend_kept", rd, 32'h8);
        applyStimulus(1'b1, 15'd4, 32'h0, 4'hF, rd, rd8, outSnap, oeSnap);
        applyStimulus(1'b0, 15'd5, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("ie_clear_keeps_pend", rd, 32'h8);
        checkOutput("ie_clear_irq", 32'(irq), 32'd1);

        // Asynchronous reset during the ready cycle.
        @(negedge aclk);
        bus.slv_en   = 1'b1;
        bus.slv_wr   = 1'b0;
        bus.slv_addr = 15'd0;
        waitCycles(1);
        checkOutput("midacc_ready", 32'(bus.slv_ready), 32'd1);
        checkOutput("midacc_rdata", bus.slv_rdata, 32'h1800FF33);
        aresetn = 1'b0;
        #1;
        bus.slv_en = 1'b0;
        checkOutput("areset_ready", 32'(bus.slv_ready), 32'd0);
        checkOutput("areset_rdata", bus.slv_rdata, 32'h0);
        checkOutput("areset_gpio_out", gpio_out, 32'h0);
        checkOutput("areset_gpio_oe", gpio_oe, 32'h0);
        checkOutput("areset_irq", 32'(irq), 32'd0);
        gpio_in = 32'h0;
        waitCycles(2);
        @(negedge aclk);
        aresetn = 1'b1;
        waitCycles(4);
        applyStimulus(1'b0, 15'd5, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("areset_pend", rd, 32'h0);

        // Synchronous reset clears state at the next edge.
        applyStimulus(1'b1, 15'd0, 32'h00000055, 4'hF, rd, rd8, outSnap, oeSnap);
        checkOutput("pre_srst_out", outSnap, 32'h00000055);
        @(negedge aclk);
        srst = 1'b1;
        waitCycles(1);
        checkOutput("srst_gpio_out", gpio_out, 32'h0);
        @(negedge aclk);
        srst = 1'b0;
        applyStimulus(1'b0, 15'd0, 32'h0, 4'h0, rd, rd8, outSnap, oeSnap);
        checkOutput("srst_out_read", rd, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got 0x%08h, expected 0x%08h", 32'(checkCount), 32'hFFFFFFFF);
        $fatal(1, "[TB] timeout");
    end

endmodule
